// File: rtl/vga_tile_display.sv
// Tile-mapped VGA driver: programmable timing and pixel divider, screen-memory then bitmap-memory fetch.
// RGB and syncs leave through a 3-tick pixel pipeline, so both stay aligned.
module vga_tile_display #(
    parameter int          H_ACTIVE  = 640,
    parameter int          H_FP      = 16,
    parameter int          H_SYNC    = 96,
    parameter int          H_BP      = 48,
    parameter int          V_ACTIVE  = 480,
    parameter int          V_FP      = 10,
    parameter int          V_SYNC    = 2,
    parameter int          V_BP      = 33,
    parameter logic        HSYNC_POL = 1'b0,
    parameter logic        VSYNC_POL = 1'b0,
    parameter int          PIX_DIV   = 2,
    parameter int          TILE_LOG2 = 4,
    parameter int          CHAR_W    = 3,
    parameter int          SCR_AW    = 11,
    parameter logic [7:0]  BG_COLOR  = 8'h00
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            display_en,
    input  logic [CHAR_W-1:0]               character,
    input  logic [7:0]                      colorValue,
    output logic [SCR_AW-1:0]               screenAddr,
    output logic [CHAR_W+2*TILE_LOG2-1:0]   bitmapAddr,
    output logic [2:0]                      red,
    output logic [2:0]                      green,
    output logic [1:0]                      blue,
    output logic                            hsync,
    output logic                            vsync,
    output logic                            frame_start,
    output logic [10:0]                     hcount,
    output logic [9:0]                      vcount
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int COLS    = H_ACTIVE >> TILE_LOG2;
    localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    logic [DIV_W-1:0]     div_cnt;
    logic [DIV_W-1:0]     div_nxt;
    logic                 pix_en;

    logic                 act0;
    logic                 hs0;
    logic                 vs0;
    logic [SCR_AW-1:0]    scr_addr0;

    logic [TILE_LOG2-1:0] xoff1;
    logic [TILE_LOG2-1:0] yoff1;
    logic                 act1, hs1, vs1;
    logic                 act2, hs2, vs2;

    // pix_en is registered so it is low in reset, even when PIX_DIV is 1.
    always_comb begin
        div_nxt = (div_cnt == DIV_W'(PIX_DIV - 1)) ? '0 : div_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            pix_en  <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            pix_en  <= (div_nxt == DIV_W'(PIX_DIV - 1));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcount <= '0;
            vcount <= '0;
        end else if (pix_en) begin
            if (hcount == 11'(H_TOTAL - 1)) begin
                hcount <= '0;
                vcount <= (vcount == 10'(V_TOTAL - 1)) ? '0 : vcount + 1'b1;
            end else begin
                hcount <= hcount + 1'b1;
            end
        end
    end

    assign frame_start = pix_en && (hcount == '0) && (vcount == '0);

    always_comb begin
        act0 = (hcount < 11'(H_ACTIVE)) && (vcount < 10'(V_ACTIVE));
        hs0  = ((hcount >= 11'(H_ACTIVE + H_FP)) && (hcount < 11'(H_ACTIVE + H_FP + H_SYNC)))
               ? HSYNC_POL : ~HSYNC_POL;
        vs0  = ((vcount >= 10'(V_ACTIVE + V_FP)) && (vcount < 10'(V_ACTIVE + V_FP + V_SYNC)))
               ? VSYNC_POL : ~VSYNC_POL;
        // Arithmetic is done modulo 2**SCR_AW, matching the address truncation.
        scr_addr0 = SCR_AW'(vcount >> TILE_LOG2) * SCR_AW'(COLS) + SCR_AW'(hcount >> TILE_LOG2);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            screenAddr <= '0;
            xoff1      <= '0;
            yoff1      <= '0;
            act1       <= 1'b0;
            hs1        <= ~HSYNC_POL;
            vs1        <= ~VSYNC_POL;
            bitmapAddr <= '0;
            act2       <= 1'b0;
            hs2        <= ~HSYNC_POL;
            vs2        <= ~VSYNC_POL;
            red        <= '0;
            green      <= '0;
            blue       <= '0;
            hsync      <= ~HSYNC_POL;
            vsync      <= ~VSYNC_POL;
        end else if (pix_en) begin
            screenAddr <= scr_addr0;
            xoff1      <= hcount[TILE_LOG2-1:0];
            yoff1      <= vcount[TILE_LOG2-1:0];
            act1       <= act0;
            hs1        <= hs0;
            vs1        <= vs0;

            bitmapAddr <= {character, yoff1, xoff1};
            act2       <= act1;
            hs2        <= hs1;
            vs2        <= vs1;

            if (!act2)
                {red, green, blue} <= 8'h00;
            else if (display_en)
                {red, green, blue} <= colorValue;
            else
                {red, green, blue} <= BG_COLOR;
            hsync      <= hs2;
            vsync      <= vs2;
        end
    end

endmodule

// File: tb/tb_vga_tile_display.sv
// Directed bench on a shrunken 80x54-pixel raster (64x48 active, PIX_DIV=2, BG 8'h1C).
// Pixel (h,v) of frame f is ticked at clk 2+2*(80*v+h)+8640*f after reset release; its RGB/sync appear 4 clk later.
module tb_vga_tile_display;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        display_en = 1'b1;
    logic [2:0]  character;
    logic [7:0]  colorValue;
    logic [10:0] screenAddr;
    logic [10:0] bitmapAddr;
    logic [2:0]  red;
    logic [2:0]  green;
    logic [1:0]  blue;
    logic        hsync;
    logic        vsync;
    logic        frame_start;
    logic [10:0] hcount;
    logic [9:0]  vcount;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    vga_tile_display #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .PIX_DIV(2), .TILE_LOG2(4), .CHAR_W(3), .SCR_AW(11),
        .BG_COLOR(8'h1C)
    ) dut (
        .clk(clk), .reset(reset), .display_en(display_en),
        .character(character), .colorValue(colorValue),
        .screenAddr(screenAddr), .bitmapAddr(bitmapAddr),
        .red(red), .green(green), .blue(blue),
        .hsync(hsync), .vsync(vsync), .frame_start(frame_start),
        .hcount(hcount), .vcount(vcount)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Synchronous-read memories, one clk latency.
    always @(posedge clk) begin
        character  <= screenAddr[2:0] ^ 3'b011;
        colorValue <= bitmapAddr[7:0] ^ 8'hA0;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rgb"},   32'({red, green, blue}), 32'h00);
        chk({tag, "_hs"},    32'(hsync), 32'h1);
        chk({tag, "_vs"},    32'(vsync), 32'h1);
        chk({tag, "_saddr"}, 32'(screenAddr), 32'h0);
        chk({tag, "_baddr"}, 32'(bitmapAddr), 32'h0);
        chk({tag, "_fs"},    32'(frame_start), 32'h0);
        chk({tag, "_pos"},   32'({hcount, vcount}), 32'h0);
    endtask

    initial begin
        bit hs_ok;

        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Start of frame 0 and line wrap.
        wait_cyc(1);   chk("fs_first",  32'(frame_start), 1);
        wait_cyc(2);   chk("fs_pulse",  32'(frame_start), 0);
        wait_cyc(3);   chk("hcnt_1",    32'(hcount), 1);
        wait_cyc(159); chk("pos_79_0",  32'({hcount, vcount}), {11'd79, 10'd0});
        wait_cyc(160); chk("pos_0_1",   32'({hcount, vcount}), {11'd0, 10'd1});

        // Address and colour pipeline around (35,20): tile 6, character 5.
        wait_cyc(3264); chk("saddr_31_20", 32'(screenAddr), 5);
        wait_cyc(3272); chk("saddr_35_20", 32'(screenAddr), 6);
        wait_cyc(3274); chk("baddr_35_20", 32'(bitmapAddr), 1347);
        wait_cyc(3275); chk("rgb_34_20",   32'({red, green, blue}), 32'hE2);
        wait_cyc(3276); chk("rgb_35_20",   32'({red, green, blue}), 32'hE3);

        // hsync low for pixels 68..75 -> clk 3342..3357 on line 20.
        wait_cyc(3341); chk("hs_pre",     32'(hsync), 1);
        wait_cyc(3342); chk("hs_start",   32'(hsync), 0);
        wait_cyc(3346); chk("rgb_h70",    32'({red, green, blue}), 32'h00);
        wait_cyc(3357); chk("hs_end",     32'(hsync), 0);
        wait_cyc(3358); chk("hs_post",    32'(hsync), 1);

        wait_cyc(7546); chk("rgb_10_47",  32'({red, green, blue}), 32'h5A);
        wait_cyc(7706); chk("rgb_10_48",  32'({red, green, blue}), 32'h00);

        // vsync low on lines 50 and 51.
        wait_cyc(8005); chk("vs_pre",     32'(vsync), 1);
        wait_cyc(8006); chk("vs_start",   32'(vsync), 0);
        wait_cyc(8325); chk("vs_end",     32'(vsync), 0);
        wait_cyc(8326); chk("vs_post",    32'(vsync), 1);

        wait_cyc(8640); chk("fs1_pre",    32'(frame_start), 0);
        wait_cyc(8641); chk("fs1",        32'(frame_start), 1);
        wait_cyc(8642); chk("fs1_post",   32'(frame_start), 0);

        // Frame 1 with display disabled: background in active area, syncs unchanged.
        wait_cyc(8700); display_en = 1'b0;
        wait_cyc(11916); chk("bg_35_20",  32'({red, green, blue}), 32'h1C);
        wait_cyc(11981); chk("bg_hs_pre", 32'(hsync), 1);
        wait_cyc(11982); chk("bg_hs_st",  32'(hsync), 0);
        wait_cyc(11986); chk("bg_h70",    32'({red, green, blue}), 32'h00);
        wait_cyc(11997); chk("bg_hs_end", 32'(hsync), 0);
        wait_cyc(11998); chk("bg_hs_post",32'(hsync), 1);
        wait_cyc(12000); display_en = 1'b1;

        wait_cyc(17280); chk("fs2_pre",   32'(frame_start), 0);
        wait_cyc(17281); chk("fs2",       32'(frame_start), 1);

        // Mid-frame reset at (40,25) of frame 2.
        wait_cyc(21362); chk("pos_41_25", 32'({hcount, vcount}), {11'd41, 10'd25});
        reset = 1'b1;
        #1;
        chk_reset_vals("midrst");
        repeat (5) @(negedge clk);
        reset = 1'b0;

        hs_ok = 1'b1;
        for (int n = 1; n <= 141; n++) begin
            wait_cyc(n);
            if (hsync !== 1'b1) hs_ok = 1'b0;
            if (n == 1) chk("fs_restart", 32'(frame_start), 1);
            if (n == 5) chk("rgb_restart_pre", 32'({red, green, blue}), 32'h00);
            if (n == 6) chk("rgb_restart_0_0", 32'({red, green, blue}), 32'hA0);
        end
        chk("no_partial_hs", 32'(hs_ok), 1);
        wait_cyc(142); chk("hs_restart", 32'(hsync), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
